// File: rtl/fifo_gearbox.sv
// fifo_gearbox: width-converting lane FIFO, power-of-two pack/unpack ratios in either direction.
// Optional sticky overflow_err/underflow_err outputs when FIFO_GEARBOX_ERR_EN is defined.
module fifo_gearbox #(
  parameter int unsigned R_DATA_WIDTH  = 16,
  parameter int unsigned W_DATA_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH    = 256,
  parameter int unsigned ALMOST_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write_request,
  input  logic                        read_request,
  input  logic [W_DATA_WIDTH-1:0]     wr_data,
  output logic [R_DATA_WIDTH-1:0]     rd_data,
  output logic                        full_flag,
  output logic                        empty_flag,
  output logic                        almost_full_flag,
  output logic                        almost_empty_flag,
  output logic [$clog2(FIFO_DEPTH):0] fill_count
`ifdef FIFO_GEARBOX_ERR_EN
  ,
  output logic                        overflow_err,
  output logic                        underflow_err
`endif
);

  localparam int unsigned LANE_W = (R_DATA_WIDTH < W_DATA_WIDTH) ? R_DATA_WIDTH : W_DATA_WIDTH;
  localparam int unsigned WL     = W_DATA_WIDTH / LANE_W;
  localparam int unsigned RL     = R_DATA_WIDTH / LANE_W;
  localparam int unsigned MAXL   = (WL > RL) ? WL : RL;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;

  // Reject non-power-of-two widths and depths that would let a word straddle the wrap.
  if (((R_DATA_WIDTH & (R_DATA_WIDTH - 1)) != 0) ||
      ((W_DATA_WIDTH & (W_DATA_WIDTH - 1)) != 0) ||
      ((FIFO_DEPTH % MAXL) != 0)) begin : g_bad_cfg
    $error("fifo_gearbox: widths must be powers of two and FIFO_DEPTH a multiple of max(WL,RL)");
  end

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_fill;
  logic [LANE_W-1:0] r_mem [FIFO_DEPTH];

  logic [CW-1:0]     w_free;
  logic              w_wacc;
  logic              w_racc;

  // Word-granular status derived from the registered lane count.
  assign w_free            = CW'(FIFO_DEPTH) - r_fill;
  assign full_flag         = (w_free < CW'(WL));
  assign empty_flag        = (r_fill < CW'(RL));
  assign almost_full_flag  = ((32'(w_free) / WL) <= ALMOST_THRESH);
  assign almost_empty_flag = ((32'(r_fill) / RL) <= ALMOST_THRESH);
  assign fill_count        = r_fill;

  assign w_wacc = write_request & ~full_flag;
  assign w_racc = read_request & ~empty_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_wacc) r_wr_ptr <= r_wr_ptr + AW'(WL);
      if (w_racc) r_rd_ptr <= r_rd_ptr + AW'(RL);
      r_fill <= r_fill + (w_wacc ? CW'(WL) : '0) - (w_racc ? CW'(RL) : '0);
    end
  end

  // Lane storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wacc) begin
      for (int i = 0; i < int'(WL); i++) begin
        r_mem[r_wr_ptr + AW'(i)] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  // Show-ahead read word; lane 0 is the oldest.
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < int'(RL); j++) begin
      rd_data[j*LANE_W +: LANE_W] = r_mem[r_rd_ptr + AW'(j)];
    end
  end

`ifdef FIFO_GEARBOX_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (write_request & full_flag);
      r_unf <= r_unf | (read_request & empty_flag);
    end
  end

  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;
`endif

endmodule

// File: tb/tb_fifo_gearbox.sv
// Bench for fifo_gearbox: 64->16 unpack and 16->64 pack instances against a lane-queue model.
module tb_fifo_gearbox;

  logic        clk;
  logic        reset;

  logic        a_wr, a_rd;
  logic [63:0] a_wdata;
  logic [15:0] a_rdata;
  logic        a_full, a_empty, a_af, a_ae;
  logic [8:0]  a_fill;

  logic        b_wr, b_rd;
  logic [15:0] b_wdata;
  logic [63:0] b_rdata;
  logic        b_full, b_empty, b_af, b_ae;
  logic [8:0]  b_fill;

`ifdef FIFO_GEARBOX_ERR_EN
  logic a_ovf, a_unf, b_ovf, b_unf;
`endif

  fifo_gearbox #(.R_DATA_WIDTH(16), .W_DATA_WIDTH(64), .FIFO_DEPTH(256), .ALMOST_THRESH(2)) u_a (
    .clk(clk), .reset(reset), .write_request(a_wr), .read_request(a_rd), .wr_data(a_wdata),
    .rd_data(a_rdata), .full_flag(a_full), .empty_flag(a_empty), .almost_full_flag(a_af),
    .almost_empty_flag(a_ae), .fill_count(a_fill)
`ifdef FIFO_GEARBOX_ERR_EN
    , .overflow_err(a_ovf), .underflow_err(a_unf)
`endif
  );

  fifo_gearbox #(.R_DATA_WIDTH(64), .W_DATA_WIDTH(16), .FIFO_DEPTH(256), .ALMOST_THRESH(2)) u_b (
    .clk(clk), .reset(reset), .write_request(b_wr), .read_request(b_rd), .wr_data(b_wdata),
    .rd_data(b_rdata), .full_flag(b_full), .empty_flag(b_empty), .almost_full_flag(b_af),
    .almost_empty_flag(b_ae), .fill_count(b_fill)
`ifdef FIFO_GEARBOX_ERR_EN
    , .overflow_err(b_ovf), .underflow_err(b_unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: lanes in arrival order, oldest at index 0.
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic        m_a_ovf, m_a_unf, m_b_ovf, m_b_unf;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [63:0] data;
    logic [15:0] exp_rd;
    logic        exp_empty;
    int          exp_fill;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int fa = qa.size();
    int fb = qb.size();
    chk("a_fill",  64'(a_fill),  64'(fa));
    chk("a_full",  64'(a_full),  64'((256 - fa) < 4));
    chk("a_empty", 64'(a_empty), 64'(fa < 1));
    chk("a_af",    64'(a_af),    64'(((256 - fa) / 4) <= 2));
    chk("a_ae",    64'(a_ae),    64'(fa <= 2));
    if (fa >= 1) chk("a_rdata", 64'(a_rdata), 64'(qa[0]));
    chk("b_fill",  64'(b_fill),  64'(fb));
    chk("b_full",  64'(b_full),  64'((256 - fb) < 1));
    chk("b_empty", 64'(b_empty), 64'(fb < 4));
    chk("b_af",    64'(b_af),    64'((256 - fb) <= 2));
    chk("b_ae",    64'(b_ae),    64'((fb / 4) <= 2));
    if (fb >= 4) chk("b_rdata", b_rdata, {qb[3], qb[2], qb[1], qb[0]});
`ifdef FIFO_GEARBOX_ERR_EN
    chk("a_ovf", 64'(a_ovf), 64'(m_a_ovf));
    chk("a_unf", 64'(a_unf), 64'(m_a_unf));
    chk("b_ovf", 64'(b_ovf), 64'(m_b_ovf));
    chk("b_unf", 64'(b_unf), 64'(m_b_unf));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, compare at the next negedge.
  task automatic tick(input logic wa, input logic ra, input logic [63:0] da,
                      input logic wb, input logic rb, input logic [15:0] db);
    bit acc_wa, acc_ra, acc_wb, acc_rb;
    a_wr = wa; a_rd = ra; a_wdata = da;
    b_wr = wb; b_rd = rb; b_wdata = db;
    acc_wa = wa && ((256 - qa.size()) >= 4);
    acc_ra = ra && (qa.size() >= 1);
    acc_wb = wb && ((256 - qb.size()) >= 1);
    acc_rb = rb && (qb.size() >= 4);
    if (wa && !acc_wa) m_a_ovf = 1'b1;
    if (ra && !acc_ra) m_a_unf = 1'b1;
    if (wb && !acc_wb) m_b_ovf = 1'b1;
    if (rb && !acc_rb) m_b_unf = 1'b1;
    @(posedge clk);
    if (acc_ra) void'(qa.pop_front());
    if (acc_wa) for (int i = 0; i < 4; i++) qa.push_back(da[16*i +: 16]);
    if (acc_rb) for (int i = 0; i < 4; i++) void'(qb.pop_front());
    if (acc_wb) qb.push_back(db);
    @(negedge clk);
    a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    check_all();
  endtask

  // Asynchronous reset between clock edges; effect must be immediate.
  task automatic do_reset();
    a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    #2 reset = 1'b1;
    qa.delete(); qb.delete();
    m_a_ovf = 1'b0; m_a_unf = 1'b0; m_b_ovf = 1'b0; m_b_unf = 1'b0;
    #1;
    chk("rst_fill",  64'(a_fill),  64'd0);
    chk("rst_empty", 64'(a_empty), 64'd1);
    chk("rst_full",  64'(a_full),  64'd0);
    chk("rst_ae",    64'(a_ae),    64'd1);
    chk("rst_af",    64'(a_af),    64'd0);
    chk("rst_b_empty", 64'(b_empty), 64'd1);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  vec_t tbl[6];

  initial begin
    reset = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0; a_wdata = '0;
    b_wr = 1'b0; b_rd = 1'b0; b_wdata = '0;
    m_a_ovf = 1'b0; m_a_unf = 1'b0; m_b_ovf = 1'b0; m_b_unf = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset mid-stream with 12 lanes stored.
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 64'h1000 + 64'(k), 1'b0, 1'b0, '0);
    chk("t1_pre_fill", 64'(a_fill), 64'd12);
    do_reset();
    tick(1'b1, 1'b0, 64'h5555_6666_7777_8888, 1'b0, 1'b0, '0);
    chk("t1_first", 64'(a_rdata), 64'h8888);

    // Unpack order plus read-while-empty, table driven.
    do_reset();
    tbl[0] = '{1'b1, 1'b0, 64'h4444_3333_2222_1111, 16'h1111, 1'b0, 4};
    tbl[1] = '{1'b0, 1'b1, 64'h0, 16'h2222, 1'b0, 3};
    tbl[2] = '{1'b0, 1'b1, 64'h0, 16'h3333, 1'b0, 2};
    tbl[3] = '{1'b0, 1'b1, 64'h0, 16'h4444, 1'b0, 1};
    tbl[4] = '{1'b0, 1'b1, 64'h0, 16'h0000, 1'b1, 0};
    tbl[5] = '{1'b0, 1'b1, 64'h0, 16'h0000, 1'b1, 0};
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i].wr, tbl[i].rd, tbl[i].data, 1'b0, 1'b0, '0);
      chk($sformatf("tbl%0d_fill", i), 64'(a_fill), 64'(tbl[i].exp_fill));
      chk($sformatf("tbl%0d_empty", i), 64'(a_empty), 64'(tbl[i].exp_empty));
      if (!tbl[i].exp_empty) chk($sformatf("tbl%0d_rd", i), 64'(a_rdata), 64'(tbl[i].exp_rd));
    end

    // Fill to capacity, overflow attempt, read+write at full, drain.
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      tick(1'b1, 1'b0, {16'(k), 16'(k), 16'(k), 16'(k + 1000)}, 1'b0, 1'b0, '0);
      chk($sformatf("t3_af_w%0d", k), 64'(a_af), 64'(k >= 62));
      chk($sformatf("t3_full_w%0d", k), 64'(a_full), 64'(k == 64));
    end
    chk("t3_fill256", 64'(a_fill), 64'd256);
    tick(1'b1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0, '0);
    chk("t3_w65_fill", 64'(a_fill), 64'd256);
    chk("t3_w65_head", 64'(a_rdata), 64'd1001);
`ifdef FIFO_GEARBOX_ERR_EN
    chk("t3_ovf", 64'(a_ovf), 64'd1);
`endif
    tick(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, '0);
    chk("t4_full_rw", 64'(a_fill), 64'd255);
    for (int k = 0; k < 300 && qa.size() > 0; k++) tick(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    chk("t3_drained", 64'(a_fill), 64'd0);

    // Simultaneous read and write at fill 4.
    do_reset();
    tick(1'b1, 1'b0, 64'h0004_0003_0002_0001, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b1, 64'h0008_0007_0006_0005, 1'b0, 1'b0, '0);
    chk("t4_fill7", 64'(a_fill), 64'd7);
    chk("t4_head", 64'(a_rdata), 64'h0002);
    for (int k = 0; k < 7; k++) tick(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    chk("t4_empty", 64'(a_empty), 64'd1);

    // Underflow while empty, sticky across idle cycles.
    do_reset();
    tick(1'b0, 1'b1, '0, 1'b0, 1'b1, '0);
    chk("t5_fill", 64'(a_fill), 64'd0);
    for (int k = 0; k < 100; k++) tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
`ifdef FIFO_GEARBOX_ERR_EN
    chk("t5_unf_hold", 64'(a_unf), 64'd1);
`endif
    tick(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, '0);
    chk("t5_rdptr0", 64'(a_rdata), 64'hCDEF);

    // Pack: 16 -> 64.
    do_reset();
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'hAAAA);
    chk("t6_e1", 64'(b_empty), 64'd1);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'hBBBB);
    chk("t6_e2", 64'(b_empty), 64'd1);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'hCCCC);
    chk("t6_e3", 64'(b_empty), 64'd1);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'hDDDD);
    chk("t6_e4", 64'(b_empty), 64'd0);
    chk("t6_word", b_rdata, 64'hDDDD_CCCC_BBBB_AAAA);

    // Random stress with varying write/read bias to exercise full, empty and wrap.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      int ph = (c / 1000) % 4;
      int wp = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 15 : 60;
      int rp = (ph == 0) ? 30 : (ph == 1) ? 50 : (ph == 2) ? 90 : 55;
      tick(logic'($urandom_range(0, 99) < wp), logic'($urandom_range(0, 99) < 100 - wp + 10),
           {$urandom, $urandom},
           logic'($urandom_range(0, 99) < wp), logic'($urandom_range(0, 99) < rp),
           16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
